// File: rtl/mcfu_issue_port.sv
`default_nettype none
// ============================================================================
// Module   : mcfu_issue_port
// Purpose  : Issue-side driver for one multi-cycle execution unit port
//            (FDIV / FSQRT / integer DIV). Buffers up to DEPTH selected uops
//            and presents the oldest to the unit. It holds that uop until the
//            unit signals completion. Branch kill, branch-resolve mask
//            clearing and pipeline flush are applied to every buffered uop.
// Ports    : clk, rst (sync, active-high), Flush
//            Kill_Enable / Kill_VKillMask       - mispredict kill strobe
//            Resolve_Enable / Resolve_Mask      - speculation bits to clear
//            Sel_Valid / Sel_S2E / Sel_Ready    - scheduler enqueue side
//            Port_Valid / Port_S2E / Ready      - execution unit side
//            Perf_BusyCycles / Perf_Issued      - 64-bit perf counters
// Config   : MCFU_ISSUE_PERF_EN - when defined, the perf counters are
//            implemented. When undefined, both perf outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mcfu_issue_port #(
    parameter int DEPTH                 = 2,
    parameter int SPEC_STATES           = 4,
    parameter int PORT_S2E_LEN          = 32,
    parameter int PORT_S2E_KILLMASK_LSB = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Flush,
    input  logic                    Kill_Enable,
    input  logic [SPEC_STATES-1:0]  Kill_VKillMask,
    input  logic                    Resolve_Enable,
    input  logic [SPEC_STATES-1:0]  Resolve_Mask,
    input  logic                    Sel_Valid,
    input  logic [PORT_S2E_LEN-1:0] Sel_S2E,
    output logic                    Sel_Ready,
    output logic                    Port_Valid,
    output logic [PORT_S2E_LEN-1:0] Port_S2E,
    input  logic                    Ready,
    output logic [63:0]             Perf_BusyCycles,
    output logic [63:0]             Perf_Issued
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Entries are kept packed: slot 0 is always the head, so kill compaction
    // and retirement both reduce to a shift toward slot 0.
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [PORT_S2E_LEN-1:0] payload_q [DEPTH];
    logic [PORT_S2E_LEN-1:0] payload_d [DEPTH];
    logic [OCC_W-1:0]        occ_q, occ_d;

    logic w_head_kill;
    logic w_retire;
    logic w_enq;
    logic w_in_killed;

    function automatic logic [SPEC_STATES-1:0] f_km(input logic [PORT_S2E_LEN-1:0] p);
        return p[PORT_S2E_KILLMASK_LSB +: SPEC_STATES];
    endfunction

    function automatic logic [PORT_S2E_LEN-1:0] f_resolve(
        input logic [PORT_S2E_LEN-1:0] p,
        input logic                    en,
        input logic [SPEC_STATES-1:0]  m
    );
        logic [PORT_S2E_LEN-1:0] r;
        r = p;
        if (en) begin
            r[PORT_S2E_KILLMASK_LSB +: SPEC_STATES] = f_km(p) & ~m;
        end
        return r;
    endfunction

    // Sel_Ready depends on registered occupancy only; no path from Ready.
    assign Sel_Ready   = (occ_q < OCC_W'(DEPTH));
    assign Port_Valid  = valid_q[0];
    assign Port_S2E    = valid_q[0] ? payload_q[0] : '0;

    // Kill is judged on the pre-resolve masks.
    assign w_head_kill = Kill_Enable && (|(f_km(payload_q[0]) & Kill_VKillMask));
    assign w_retire    = valid_q[0] && Ready && !w_head_kill && !Flush;
    assign w_enq       = Sel_Valid && Sel_Ready;
    assign w_in_killed = Kill_Enable && (|(f_km(Sel_S2E) & Kill_VKillMask));

    always_comb begin
        logic             keep;
        logic [OCC_W-1:0] n;
        valid_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            payload_d[j] = '0;
        end
        n    = '0;
        keep = 1'b0;

        // Survivors move to the lowest free slot, preserving age order.
        for (int i = 0; i < DEPTH; i++) begin
            keep = valid_q[i]
                && !(Kill_Enable && (|(f_km(payload_q[i]) & Kill_VKillMask)))
                && !((i == 0) && w_retire);
            if (keep) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (OCC_W'(j) == n) begin
                        valid_d[j]   = 1'b1;
                        payload_d[j] = f_resolve(payload_q[i], Resolve_Enable, Resolve_Mask);
                    end
                end
                n = n + 1'b1;
            end
        end

        // A full buffer never enqueues (Sel_Ready=0), so slot n always exists.
        if (w_enq && !w_in_killed) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (OCC_W'(j) == n) begin
                    valid_d[j]   = 1'b1;
                    payload_d[j] = f_resolve(Sel_S2E, Resolve_Enable, Resolve_Mask);
                end
            end
            n = n + 1'b1;
        end
        occ_d = n;

        if (Flush) begin
            valid_d = '0;
            occ_d   = '0;
            for (int j = 0; j < DEPTH; j++) begin
                payload_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                payload_q[j] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int j = 0; j < DEPTH; j++) begin
                payload_q[j] <= payload_d[j];
            end
        end
    end

`ifdef MCFU_ISSUE_PERF_EN
    // Cleared by rst only; Flush leaves history intact.
    logic [63:0] busy_q, busy_d;
    logic [63:0] issued_q, issued_d;

    always_comb begin
        busy_d   = busy_q + {63'd0, valid_q[0]};
        issued_d = issued_q + {63'd0, w_retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            issued_q <= '0;
        end else begin
            busy_q   <= busy_d;
            issued_q <= issued_d;
        end
    end

    assign Perf_BusyCycles = busy_q;
    assign Perf_Issued     = issued_q;
`else
    assign Perf_BusyCycles = 64'd0;
    assign Perf_Issued     = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcfu_issue_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcfu_issue_port
// Purpose  : Self-checking bench for mcfu_issue_port. A small execution-unit
//            model (6 cycles SP, 15 cycles DP) drives Ready. Expected uops
//            are queued when enqueued and compared when they retire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcfu_issue_port;

    localparam int DEPTH = 2;
    localparam int SS    = 4;
    localparam int LEN   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            Flush = 1'b0;
    logic            Kill_Enable = 1'b0;
    logic [SS-1:0]   Kill_VKillMask = '0;
    logic            Resolve_Enable = 1'b0;
    logic [SS-1:0]   Resolve_Mask = '0;
    logic            Sel_Valid = 1'b0;
    logic [LEN-1:0]  Sel_S2E = '0;
    logic            Sel_Ready;
    logic            Port_Valid;
    logic [LEN-1:0]  Port_S2E;
    logic            Ready;
    logic [63:0]     Perf_BusyCycles;
    logic [63:0]     Perf_Issued;

    mcfu_issue_port #(
        .DEPTH                 (DEPTH),
        .SPEC_STATES           (SS),
        .PORT_S2E_LEN          (LEN),
        .PORT_S2E_KILLMASK_LSB (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Flush           (Flush),
        .Kill_Enable     (Kill_Enable),
        .Kill_VKillMask  (Kill_VKillMask),
        .Resolve_Enable  (Resolve_Enable),
        .Resolve_Mask    (Resolve_Mask),
        .Sel_Valid       (Sel_Valid),
        .Sel_S2E         (Sel_S2E),
        .Sel_Ready       (Sel_Ready),
        .Port_Valid      (Port_Valid),
        .Port_S2E        (Port_S2E),
        .Ready           (Ready),
        .Perf_BusyCycles (Perf_BusyCycles),
        .Perf_Issued     (Perf_Issued)
    );

    always #5 clk = ~clk;

    // ---------------- execution unit model ----------------
    logic [4:0] u_cnt;
    logic       u_head_kill;
    logic [4:0] u_lat;
    assign u_head_kill = Kill_Enable && (|(Port_S2E[3:0] & Kill_VKillMask));
    assign u_lat       = Port_S2E[4] ? 5'd15 : 5'd6;
    assign Ready       = Port_Valid && (u_cnt == u_lat - 5'd1);

    always @(posedge clk) begin
        if (rst || Flush || !Port_Valid || u_head_kill || Ready) u_cnt <= '0;
        else                                                     u_cnt <= u_cnt + 5'd1;
    end

    // ---------------- bench state ----------------
    int             total = 0;
    int             bad   = 0;
    logic [LEN-1:0] sb[$];
    logic [LEN-1:0] ret_q[$];
    longint         exp_busy = 0;
    longint         exp_iss  = 0;

    logic           s_pv, s_selrdy, s_retire;
    logic [LEN-1:0] s_s2e;
    logic [63:0]    s_busy, s_iss;

    int             st_busy, st_rets, st_first, st_unstable;
    logic           st_selrdy0;
    logic [LEN-1:0] st_first_s2e;
    logic           st_next_pv, st_next_selrdy;
    logic [LEN-1:0] st_next_s2e;

    function automatic logic [LEN-1:0] mk(input logic [7:0] tag, input logic dp, input logic [3:0] km);
        return {16'h0000, tag, 3'b000, dp, km};
    endfunction

    function automatic longint pe(input longint v);
`ifdef MCFU_ISSUE_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // One clock cycle: inputs already driven; sample mid-cycle; land after edge.
    task automatic cyc;
        @(negedge clk);
        s_pv     = Port_Valid;
        s_s2e    = Port_S2E;
        s_selrdy = Sel_Ready;
        s_busy   = Perf_BusyCycles;
        s_iss    = Perf_Issued;
        s_retire = Port_Valid && Ready && !u_head_kill && !Flush && !rst;
        @(posedge clk);
        #1;
    endtask

    // Runs until n_ret retirements or budget cycles, collecting observations.
    task automatic run(input int n_ret, input int budget);
        logic           prev_pv, prev_ret, after;
        logic [LEN-1:0] prev_s2e;
        st_busy = 0; st_rets = 0; st_first = -1; st_unstable = 0;
        st_selrdy0 = 1'b0; st_first_s2e = '0;
        st_next_pv = 1'b0; st_next_selrdy = 1'b0; st_next_s2e = '0;
        ret_q.delete();
        prev_pv = 1'b0; prev_ret = 1'b0; prev_s2e = '0; after = 1'b0;
        for (int k = 0; k < budget && st_rets < n_ret; k++) begin
            cyc();
            if (k == 0) st_selrdy0 = s_selrdy;
            if (after) begin
                st_next_pv = s_pv; st_next_s2e = s_s2e; st_next_selrdy = s_selrdy;
                after = 1'b0;
            end
            if (s_pv) begin
                if (st_first < 0) begin
                    st_first     = k;
                    st_first_s2e = s_s2e;
                end
                st_busy++;
                if (prev_pv && !prev_ret && (s_s2e !== prev_s2e)) st_unstable++;
            end
            if (s_retire) begin
                ret_q.push_back(s_s2e);
                if (st_rets == 0) after = 1'b1;
                st_rets++;
            end
            prev_pv = s_pv; prev_ret = s_retire; prev_s2e = s_s2e;
        end
        if (after) begin
            cyc();
            st_next_pv = s_pv; st_next_s2e = s_s2e; st_next_selrdy = s_selrdy;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        cyc(); cyc();
        total++; if (s_pv !== 1'b0) begin bad++; $display("FAIL reset_port_valid actual=%b required=0", s_pv); end
        total++; if (s_s2e !== '0) begin bad++; $display("FAIL reset_port_s2e actual=%h required=0", s_s2e); end
        total++; if (s_selrdy !== 1'b1) begin bad++; $display("FAIL reset_sel_ready actual=%b required=1", s_selrdy); end
        total++; if (s_busy !== 64'd0) begin bad++; $display("FAIL reset_perf_busy actual=%0d required=0", s_busy); end
        total++; if (s_iss !== 64'd0) begin bad++; $display("FAIL reset_perf_issued actual=%0d required=0", s_iss); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [LEN-1:0] a, e;
        a = mk(8'h11, 1'b0, 4'b0000);
        Sel_Valid = 1'b1; Sel_S2E = a; sb.push_back(a);
        cyc();
        Sel_Valid = 1'b0;
        total++; if (s_pv !== 1'b0) begin bad++; $display("FAIL single_no_bypass actual=%b required=0", s_pv); end
        run(1, 40);
        total++; if (st_rets != 1) begin bad++; $display("FAIL single_retire_count actual=%0d required=1", st_rets); end
        total++; if (st_first != 0) begin bad++; $display("FAIL single_first_valid actual=%0d required=0", st_first); end
        total++; if (st_busy != 6) begin bad++; $display("FAIL single_busy actual=%0d required=6", st_busy); end
        total++; if (st_unstable != 0) begin bad++; $display("FAIL single_stable actual=%0d required=0", st_unstable); end
        foreach (ret_q[i]) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++; if (ret_q[i] !== e) begin bad++; $display("FAIL single_retired_uop actual=%h required=%h", ret_q[i], e); end
        end
        cyc();
        exp_busy += 6; exp_iss += 1;
        total++; if (s_pv !== 1'b0) begin bad++; $display("FAIL single_idle_after actual=%b required=0", s_pv); end
        total++; if (s_busy !== 64'(pe(exp_busy))) begin bad++; $display("FAIL single_perf_busy actual=%0d required=%0d", s_busy, pe(exp_busy)); end
        total++; if (s_iss !== 64'(pe(exp_iss))) begin bad++; $display("FAIL single_perf_issued actual=%0d required=%0d", s_iss, pe(exp_iss)); end
    endtask

    task automatic test_back_to_back;
        logic [LEN-1:0] a, b, e;
        int             busy0;
        a = mk(8'h2A, 1'b1, 4'b0000);
        b = mk(8'h2B, 1'b0, 4'b0000);
        Sel_Valid = 1'b1; Sel_S2E = a; sb.push_back(a);
        cyc();
        Sel_S2E = b; sb.push_back(b);
        cyc();
        Sel_Valid = 1'b0;
        busy0 = s_pv ? 1 : 0;
        total++; if (s_selrdy !== 1'b1) begin bad++; $display("FAIL b2b_ready_one_entry actual=%b required=1", s_selrdy); end
        run(2, 80);
        total++; if (st_selrdy0 !== 1'b0) begin bad++; $display("FAIL b2b_full actual=%b required=0", st_selrdy0); end
        total++; if (st_rets != 2) begin bad++; $display("FAIL b2b_retire_count actual=%0d required=2", st_rets); end
        total++; if (busy0 + st_busy != 21) begin bad++; $display("FAIL b2b_busy actual=%0d required=21", busy0 + st_busy); end
        total++; if (st_next_pv !== 1'b1 || st_next_s2e !== b) begin bad++; $display("FAIL b2b_no_gap actual=%b/%h required=1/%h", st_next_pv, st_next_s2e, b); end
        total++; if (st_next_selrdy !== 1'b1) begin bad++; $display("FAIL b2b_ready_return actual=%b required=1", st_next_selrdy); end
        total++; if (st_unstable != 0) begin bad++; $display("FAIL b2b_stable actual=%0d required=0", st_unstable); end
        foreach (ret_q[i]) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++; if (ret_q[i] !== e) begin bad++; $display("FAIL b2b_retired_uop actual=%h required=%h", ret_q[i], e); end
        end
        cyc();
        exp_busy += 21; exp_iss += 2;
        total++; if (s_busy !== 64'(pe(exp_busy))) begin bad++; $display("FAIL b2b_perf_busy actual=%0d required=%0d", s_busy, pe(exp_busy)); end
        total++; if (s_iss !== 64'(pe(exp_iss))) begin bad++; $display("FAIL b2b_perf_issued actual=%0d required=%0d", s_iss, pe(exp_iss)); end
    endtask

    task automatic test_head_kill;
        logic [LEN-1:0] a, b, e;
        a = mk(8'h3A, 1'b0, 4'b0010);
        b = mk(8'h3B, 1'b0, 4'b0001);
        Sel_Valid = 1'b1; Sel_S2E = a; sb.push_back(a);
        cyc();
        Sel_S2E = b; sb.push_back(b);
        cyc();                                  // A busy cycle 1
        Sel_Valid = 1'b0;
        cyc();                                  // A busy cycle 2
        Kill_Enable = 1'b1; Kill_VKillMask = 4'b0010;
        void'(sb.pop_front());                  // A is the only entry hit by the kill
        cyc();                                  // A busy cycle 3, killed
        Kill_Enable = 1'b0; Kill_VKillMask = '0;
        total++; if (s_pv !== 1'b1 || s_s2e !== a) begin bad++; $display("FAIL kill_head_present actual=%b/%h required=1/%h", s_pv, s_s2e, a); end
        run(1, 40);
        total++; if (st_first != 0 || st_first_s2e !== b) begin bad++; $display("FAIL kill_next_present actual=%0d/%h required=0/%h", st_first, st_first_s2e, b); end
        total++; if (st_busy != 6) begin bad++; $display("FAIL kill_b_busy actual=%0d required=6", st_busy); end
        foreach (ret_q[i]) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++; if (ret_q[i] !== e) begin bad++; $display("FAIL kill_retired_uop actual=%h required=%h", ret_q[i], e); end
        end
        cyc();
        exp_busy += 9; exp_iss += 1;
        total++; if (s_busy !== 64'(pe(exp_busy))) begin bad++; $display("FAIL kill_perf_busy actual=%0d required=%0d", s_busy, pe(exp_busy)); end
        total++; if (s_iss !== 64'(pe(exp_iss))) begin bad++; $display("FAIL kill_perf_issued actual=%0d required=%0d", s_iss, pe(exp_iss)); end
    endtask

    task automatic test_resolve;
        logic [LEN-1:0] u, ur, e;
        u  = mk(8'h44, 1'b1, 4'b0110);
        ur = mk(8'h44, 1'b1, 4'b0010);
        Sel_Valid = 1'b1; Sel_S2E = u; sb.push_back(u);
        cyc();
        Sel_Valid = 1'b0;
        Resolve_Enable = 1'b1; Resolve_Mask = 4'b0100;
        cyc();                                  // busy 1
        Resolve_Enable = 1'b0; Resolve_Mask = '0;
        sb[0] = ur;
        cyc();                                  // busy 2
        total++; if (s_s2e !== ur) begin bad++; $display("FAIL resolve_mask_cleared actual=%h required=%h", s_s2e, ur); end
        Kill_Enable = 1'b1; Kill_VKillMask = 4'b0100;
        cyc();                                  // busy 3
        Kill_Enable = 1'b0; Kill_VKillMask = '0;
        cyc();                                  // busy 4
        total++; if (s_pv !== 1'b1 || s_s2e !== ur) begin bad++; $display("FAIL resolve_survives_kill actual=%b/%h required=1/%h", s_pv, s_s2e, ur); end
        run(1, 40);
        total++; if (st_busy != 11) begin bad++; $display("FAIL resolve_busy_rest actual=%0d required=11", st_busy); end
        foreach (ret_q[i]) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++; if (ret_q[i] !== e) begin bad++; $display("FAIL resolve_retired_uop actual=%h required=%h", ret_q[i], e); end
        end
        exp_busy += 15; exp_iss += 1;
    endtask

    task automatic test_incoming;
        logic [LEN-1:0] w, z, zr, e;
        w  = mk(8'h55, 1'b0, 4'b1000);
        z  = mk(8'h56, 1'b0, 4'b0011);
        zr = mk(8'h56, 1'b0, 4'b0010);
        Sel_Valid = 1'b1; Sel_S2E = w; Kill_Enable = 1'b1; Kill_VKillMask = 4'b1000;
        cyc();
        Kill_Enable = 1'b0; Kill_VKillMask = '0;
        Sel_S2E = z; Resolve_Enable = 1'b1; Resolve_Mask = 4'b0001; sb.push_back(zr);
        cyc();
        Sel_Valid = 1'b0; Resolve_Enable = 1'b0; Resolve_Mask = '0;
        total++; if (s_pv !== 1'b0) begin bad++; $display("FAIL incoming_kill_dropped actual=%b required=0", s_pv); end
        run(1, 30);
        total++; if (st_first != 0 || st_first_s2e !== zr) begin bad++; $display("FAIL incoming_resolve actual=%0d/%h required=0/%h", st_first, st_first_s2e, zr); end
        foreach (ret_q[i]) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++; if (ret_q[i] !== e) begin bad++; $display("FAIL incoming_retired_uop actual=%h required=%h", ret_q[i], e); end
        end
        exp_busy += 6; exp_iss += 1;
    endtask

    task automatic test_flush;
        logic [LEN-1:0] x, y, p;
        x = mk(8'h66, 1'b1, 4'b0000);
        y = mk(8'h67, 1'b0, 4'b0000);
        p = mk(8'h68, 1'b1, 4'b0000);
        Sel_Valid = 1'b1; Sel_S2E = x;
        cyc();
        Sel_S2E = y; Flush = 1'b1;
        cyc();                                  // x busy 1, flush + enqueue y
        Sel_Valid = 1'b0; Flush = 1'b0;
        sb.delete();
        total++; if (s_selrdy !== 1'b1) begin bad++; $display("FAIL flush_enq_accepted actual=%b required=1", s_selrdy); end
        cyc();
        total++; if (s_pv !== 1'b0 || s_s2e !== '0) begin bad++; $display("FAIL flush_port_idle actual=%b/%h required=0/0", s_pv, s_s2e); end
        total++; if (s_selrdy !== 1'b1) begin bad++; $display("FAIL flush_sel_ready actual=%b required=1", s_selrdy); end
        run(1, 30);
        total++; if (st_busy != 0 || st_rets != 0) begin bad++; $display("FAIL flush_never_presented actual=%0d/%0d required=0/0", st_busy, st_rets); end
        // One enqueue after the flush must leave room for another (occ back to 0).
        Sel_Valid = 1'b1; Sel_S2E = p;
        cyc();
        Sel_Valid = 1'b0; Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        total++; if (s_pv !== 1'b1 || s_selrdy !== 1'b1) begin bad++; $display("FAIL flush_occ_zero actual=%b/%b required=1/1", s_pv, s_selrdy); end
        cyc();
        exp_busy += 2;
        total++; if (s_pv !== 1'b0) begin bad++; $display("FAIL flush_second_idle actual=%b required=0", s_pv); end
        total++; if (s_busy !== 64'(pe(exp_busy))) begin bad++; $display("FAIL flush_perf_busy actual=%0d required=%0d", s_busy, pe(exp_busy)); end
        total++; if (s_iss !== 64'(pe(exp_iss))) begin bad++; $display("FAIL flush_perf_issued actual=%0d required=%0d", s_iss, pe(exp_iss)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_head_kill();
        test_resolve();
        test_incoming();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcfu_issue_port.md
# mcfu_issue_port

Issue-side driver for one multi-cycle execution unit port (FDIV, FSQRT, integer DIV) in the EX stage. It accepts selected uops from the scheduler, buffers up to `DEPTH` of them, and presents the oldest on `Port_Valid`/`Port_S2E`. It holds that uop stable until the unit signals completion through `Ready`. It applies branch kill, branch-resolve mask clearing and pipeline flush to every buffered uop.

## Interface
Parameters:
- `DEPTH`, default 2: buffer entries (2..4).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `Flush` in 1: pipeline flush; drops all entries.
- `Kill_Enable` in 1: branch mispredict kill strobe.
- `Kill_VKillMask` in `SPEC_STATES`: mispredicted speculation bit(s).
- `Resolve_Enable` in 1: correctly predicted branch resolved.
- `Resolve_Mask` in `SPEC_STATES`: speculation bit(s) to clear.
- `Sel_Valid` in 1: scheduler presents a uop.
- `Sel_S2E` in `PORT_S2E_LEN`: uop payload (same layout as the unit port).
- `Sel_Ready` out 1: buffer can accept a uop this cycle.
- `Port_Valid` out 1: uop valid to the unit.
- `Port_S2E` out `PORT_S2E_LEN`: head uop payload.
- `Ready` in 1: unit ready (combinational from the unit; 1 in its completion cycle).
- `Perf_BusyCycles` out 64: cycles with `Port_Valid`=1.
- `Perf_Issued` out 64: uops completed at the unit.

## Operation
- Circular buffer of `DEPTH` entries, each holding a valid bit and a payload, plus an occupancy count `occ`. Head = oldest accepted entry.
- `Sel_Ready` = (`occ` < `DEPTH`). It is registered-state only, with no combinational path from `Ready`.
- Enqueue when `Sel_Valid` & `Sel_Ready`.
  - An incoming uop whose killmask hits `Kill_VKillMask` while `Kill_Enable`=1 is discarded.
  - If `Resolve_Enable`=1, the incoming uop is written with `Resolve_Mask` bits cleared.
- `Port_Valid` = head valid. `Port_S2E` = head payload; it is all-zero when the buffer is empty.
- Head retires at the clock edge where `Port_Valid` & `Ready` & ~head-killed. `Perf_Issued` increments at that edge.
- Kill: every entry with `killmask & Kill_VKillMask` ≠ 0 is invalidated at the edge.
  - Survivors compact toward the head, preserving order.
  - The unit sees the same kill combinationally and resets its own counter in the same cycle.
- Resolve: `Resolve_Mask` bits are cleared in the `PORT_S2E_KILLMASK` field of all entries at the edge. The payload is otherwise unchanged.
- Simultaneous kill and resolve: kill is evaluated on the pre-clear masks, and resolve is applied to the survivors.
- Simultaneous dequeue and enqueue when full: not allowed, because `Sel_Ready`=0. When not full, both occur and `occ` is unchanged.
- `Flush` or `rst`: `occ`=0, all valids cleared. Flush has priority over enqueue in the same cycle.

## Timing
- Reset values:
  - `Port_Valid`=0, `Port_S2E`=0.
  - `Sel_Ready`=1.
  - `Perf_BusyCycles`=0, `Perf_Issued`=0.
- Enqueue into an empty buffer at edge N gives `Port_Valid`=1 in cycle N+1. There is no bypass.
- The payload is held bit-stable (apart from resolve clears) for every cycle the unit is busy.
- Completion in cycle C (`Ready`=1 with `Port_Valid`=1):
  - If another entry is buffered, the next uop is presented in C+1 and the unit restarts its count from 0.
  - Otherwise `Port_Valid`=0 in C+1.
- Kill of the head in cycle K: the surviving next entry is presented in K+1.
- Reset or flush mid-operation: `Port_Valid`=0 in the following cycle. Nothing is retired and `Perf_Issued` is unchanged.
- `Perf_Issued` does not wrap within simulation; its width is 64 bits.

## Configuration
- `MCFU_ISSUE_PERF_EN`
  - Defined: the `Perf_BusyCycles` and `Perf_Issued` counters are implemented, reset to 0, and cleared by `rst` only (not by `Flush`).
  - Undefined: both outputs are tied to 0 and no counter flops are synthesized. The ports remain present so that instantiations are identical.

## Test plan
1. **Single SP divide.** Reset, then enqueue one SP FDIV uop with `DEPTH`=2 and a unit model with 6-cycle latency.
   - `Port_Valid` is high for exactly 6 cycles starting 1 cycle after enqueue.
   - The payload is constant throughout.
   - `Perf_Issued`=1 and `Perf_BusyCycles`=6.
2. **Back-to-back issue.** Enqueue DP uop A and then SP uop B on consecutive cycles, with 15-cycle DP and 6-cycle SP latency.
   - `Sel_Ready`=0 after both are enqueued.
   - B is presented in the cycle immediately after A's completion cycle, with no idle cycle.
   - Total busy is 21 cycles and `Sel_Ready` returns to 1 when A retires.
3. **Head kill.** Head A has killmask `0b0010`; B behind it has `0b0001`. Pulse `Kill_Enable` with `Kill_VKillMask`=`0b0010` in A's 3rd busy cycle.
   - A is dropped without retiring.
   - B is presented on the next cycle.
   - `Perf_Issued` increments only when B completes.
4. **Resolve.** Buffered uop has killmask `0b0110`; pulse `Resolve_Enable` with `Resolve_Mask`=`0b0100`.
   - `Port_S2E` killmask reads `0b0010` on the next cycle.
   - A subsequent kill with mask `0b0100` does not drop the uop.
5. **Concurrent flush and enqueue.** Assert `Flush` in the same cycle as an enqueue, with 1 entry already busy.
   - `Port_Valid`=0 on the next cycle.
   - `occ`=0 and `Sel_Ready`=1.
   - The enqueued uop is never presented.
6. **Macro undefined.** Rerun scenario 2 without `MCFU_ISSUE_PERF_EN`.
   - Behaviour is identical except `Perf_BusyCycles`=`Perf_Issued`=0 throughout.
